// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush sequencer.
// The master side raises hazard/branch/memory/halt events; the slave side returns enables, flushes and status.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             hz_stall;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_req;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] hz_stall_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hz_stall, br_taken, mem_req, mem_ready, halt_req,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
        input  halted, mem_err, hz_stall_cnt, mem_wait_cnt, flush_cnt
    );

    modport slave (
        input  hz_stall, br_taken, mem_req, mem_ready, halt_req,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush,
        output halted, mem_err, hz_stall_cnt, mem_wait_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: merges hazard, branch, memory and halt
// events into per-stage enables/flushes, with saturating event counters and a memory watchdog.
module pipeline_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           clock,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);
    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_HALT     = 2'd2;
    localparam logic [7:0] W_TIMEOUT  = 8'(MEM_TIMEOUT);

    logic [1:0]       r_state;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_hz_cnt;
    logic [CNT_W-1:0] r_mw_cnt;
    logic [CNT_W-1:0] r_fl_cnt;
    logic             r_halted;
    logic             r_mem_err;

    logic [1:0]       w_next_state;
    logic [7:0]       w_wait_next;
    logic             w_mem_stall;
    logic             w_inc_hz;
    logic             w_inc_mw;
    logic             w_inc_fl;
    logic             w_set_err;
    logic             w_pc_en;
    logic             w_if_id_en;
    logic             w_id_ex_en;
    logic             w_ex_mem_en;
    logic             w_mem_wb_en;
    logic             w_if_id_flush;
    logic             w_id_ex_flush;
    logic             w_mem_wb_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    assign w_mem_stall = bus.mem_req & ~bus.mem_ready;

    // Priority resolution of control outputs and next-state/counter intents.
    always_comb begin
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_en    = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_mem_wb_flush = 1'b0;
        w_next_state   = r_state;
        w_wait_next    = r_wait_cnt;
        w_inc_hz       = 1'b0;
        w_inc_mw       = 1'b0;
        w_inc_fl       = 1'b0;
        w_set_err      = 1'b0;
        if (reset) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_mem_wb_flush = 1'b1;
            w_next_state   = S_RUN;
            w_wait_next    = 8'd0;
        end else begin
            case (r_state)
                S_RUN, S_MEM_WAIT: begin
                    if (bus.halt_req) begin
                        w_next_state = S_HALT;
                    end else if (w_mem_stall) begin
                        w_mem_wb_flush = 1'b1;
                        w_inc_mw       = 1'b1;
                        if (r_state == S_RUN) begin
                            w_next_state = S_MEM_WAIT;
                            w_wait_next  = 8'd1;
                        end else if (r_wait_cnt == W_TIMEOUT) begin
                            // Watchdog: memory never answered within the allowed window.
                            w_next_state = S_HALT;
                            w_set_err    = 1'b1;
                        end else begin
                            w_wait_next = r_wait_cnt + 8'd1;
                        end
                    end else begin
                        w_next_state = S_RUN;
                        if (bus.br_taken) begin
                            // Branch beats a RAW stall: the stalled instruction is wrong-path.
                            w_pc_en       = 1'b1;
                            w_if_id_en    = 1'b1;
                            w_id_ex_en    = 1'b1;
                            w_ex_mem_en   = 1'b1;
                            w_mem_wb_en   = 1'b1;
                            w_if_id_flush = 1'b1;
                            w_id_ex_flush = 1'b1;
                            w_inc_fl      = 1'b1;
                        end else if (bus.hz_stall) begin
                            w_id_ex_en    = 1'b1;
                            w_ex_mem_en   = 1'b1;
                            w_mem_wb_en   = 1'b1;
                            w_id_ex_flush = 1'b1;
                            w_inc_hz      = 1'b1;
                        end else begin
                            w_pc_en     = 1'b1;
                            w_if_id_en  = 1'b1;
                            w_id_ex_en  = 1'b1;
                            w_ex_mem_en = 1'b1;
                            w_mem_wb_en = 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    w_next_state = S_HALT;
                end
                default: begin
                    w_next_state = S_RUN;
                end
            endcase
        end
    end

    // State, watchdog, status flags and saturating counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
            r_hz_cnt   <= '0;
            r_mw_cnt   <= '0;
            r_fl_cnt   <= '0;
            r_halted   <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
            r_halted   <= (w_next_state == S_HALT);
            r_mem_err  <= r_mem_err | w_set_err;
            if (w_inc_hz) begin
                r_hz_cnt <= sat_inc(r_hz_cnt);
            end
            if (w_inc_mw) begin
                r_mw_cnt <= sat_inc(r_mw_cnt);
            end
            if (w_inc_fl) begin
                r_fl_cnt <= sat_inc(r_fl_cnt);
            end
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.id_ex_en     = w_id_ex_en;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.mem_wb_en    = w_mem_wb_en;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.halted       = r_halted;
    assign bus.mem_err      = r_mem_err;
    assign bus.hz_stall_cnt = r_hz_cnt;
    assign bus.mem_wait_cnt = r_mw_cnt;
    assign bus.flush_cnt    = r_fl_cnt;

endmodule
